// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage (ID/EX) with a two-entry skid buffer on valid/ready.
// Define IMM_EXT_BRANCH_EN to build the branch-target adder for ext_op 4; otherwise mode 4 is reserved.
module imm_ext_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  din,
  input  logic [2:0]       ext_op,
  input  logic [OUT_W-1:0] base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dout,
  output logic             out_err
);

  // Handshake: a beat transfers on a rising edge where valid && ready are both high.
  // in_ready is a register (skid empty), so it never depends on out_ready in the same cycle.

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] res;
  logic             res_err;

  assign sext = {{(OUT_W-IN_W){din[IN_W-1]}}, din};

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (ext_op)
      3'd0: res = {{(OUT_W-IN_W){1'b0}}, din};
      3'd1: res = sext;
      3'd2: res = {din, {(OUT_W-IN_W){1'b0}}};
      3'd3: res = sext << 2;
`ifdef IMM_EXT_BRANCH_EN
      3'd4: res = base + (sext << 2);
`endif
      default: begin
        res     = '0;
        res_err = 1'b1;
      end
    endcase
  end

`ifndef IMM_EXT_BRANCH_EN
  logic unused_base;
  assign unused_base = ^base;
`endif

  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] main_data_q, main_data_d;
  logic             main_err_q, main_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
  logic             in_ready_q, in_ready_d;
  logic             accept;
  logic             pop;

  assign accept = in_valid && in_ready_q && !flush;
  assign pop    = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_err_d   = main_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    if (flush) begin
      // Output data registers keep their last values; only validity is dropped.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop && skid_valid_q) begin
      main_data_d  = skid_data_q;
      main_err_d   = skid_err_q;
      skid_valid_d = 1'b0;
    end else if (pop || !main_valid_q) begin
      main_valid_d = accept;
      if (accept) begin
        main_data_d = res;
        main_err_d  = res_err;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = res;
      skid_err_d   = res_err;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_err_q   <= main_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign dout      = main_data_q;
  assign out_err   = main_err_q;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed + random bench for imm_ext_stage; expected {out_err,dout} values queue up at acceptance
// and are compared when the stage delivers them.
module tb_imm_ext_stage;
  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  din;
  logic [2:0]       ext_op;
  logic [OUT_W-1:0] base;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] dout;
  logic             out_err;

  imm_ext_stage #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .ext_op(ext_op), .base(base),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .out_err(out_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [OUT_W:0] exp_q[$];
  logic [OUT_W:0] cur_exp;
  logic           hold_q = 1'b0;
  logic [OUT_W:0] hold_val;

  task automatic check(input string tag, input logic [OUT_W:0] obs, input logic [OUT_W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model, {err, value}
  function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] d, input logic [2:0] op,
                                           input logic [OUT_W-1:0] b);
    logic signed [OUT_W-1:0] s;
    s = $signed(d);
    case (op)
      3'd0: return {1'b0, 16'h0000, d};
      3'd1: return {1'b0, s};
      3'd2: return {1'b0, d, 16'h0000};
      3'd3: return {1'b0, 32'(s * 4)};
`ifdef IMM_EXT_BRANCH_EN
      3'd4: return {1'b0, 32'(b + 32'(s * 4))};
`endif
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        check("hold_valid", {32'b0, out_valid}, 33'd1);
        check("hold_data", {out_err, dout}, hold_val);
      end
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_output observed=%h expected=none", {out_err, dout});
        end
        if (exp_q.size() != 0) check("out_data", {out_err, dout}, exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      if (in_valid && in_ready && !flush) exp_q.push_back(cur_exp);
      hold_q   = !flush && out_valid && !out_ready;
      hold_val = {out_err, dout};
    end
  end

  // driver tasks (all start and end at posedge+1)
  task automatic drive(input logic [IN_W-1:0] d, input logic [2:0] op,
                       input logic [OUT_W-1:0] b, input logic [OUT_W:0] e, output int waits);
    din = d; ext_op = op; base = b; cur_exp = e; in_valid = 1'b1; waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("in_ready_wait", {32'b0, in_ready}, 33'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check(tag, 33'(exp_q.size()), 33'd0);
    @(negedge clk);
    check({tag, "_idle"}, {32'b0, out_valid}, 33'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n_acc;
    logic acc;
    logic [OUT_W:0] e;
    logic [IN_W-1:0] rd;
    logic [2:0] rop;
    logic [OUT_W-1:0] rb;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    din = '0; ext_op = '0; base = '0; cur_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", {32'b0, out_valid}, 33'd0);
    check("rst_dout", {out_err, dout}, 33'd0);
    check("rst_in_ready", {32'b0, in_ready}, 33'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Modes 0..3 streamed back to back: no stalls with out_ready high
    drive(16'h8004, 3'd0, 32'h0, {1'b0, 32'h00008004}, w);
    drive(16'h8004, 3'd1, 32'h0, {1'b0, 32'hFFFF8004}, w);
    check("stream_wait1", 33'(w), 33'd0);
    drive(16'h8004, 3'd2, 32'h0, {1'b0, 32'h80040000}, w);
    check("stream_wait2", 33'(w), 33'd0);
    drive(16'h8004, 3'd3, 32'h0, {1'b0, 32'hFFFE0010}, w);
    check("stream_wait3", 33'(w), 33'd0);
    in_valid = 1'b0;
    drain("modes_drain");

    // Single-entry latency
    drive(16'h8004, 3'd3, 32'h0, {1'b0, 32'hFFFE0010}, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_valid", {32'b0, out_valid}, 33'd1);
    check("latency_data", {out_err, dout}, {1'b0, 32'hFFFE0010});
    @(posedge clk); #1;
    @(negedge clk);
    check("hold_after_pop", {out_err, dout}, {1'b0, 32'hFFFE0010});
    @(posedge clk); #1;

    // Branch target
`ifdef IMM_EXT_BRANCH_EN
    drive(16'hFFFF, 3'd4, 32'h00400010, {1'b0, 32'h0040000C}, w);
    drive(16'h0002, 3'd4, 32'hFFFFFFFC, {1'b0, 32'h00000004}, w);
`else
    drive(16'hFFFF, 3'd4, 32'h00400010, {1'b1, 32'h0}, w);
    drive(16'h0002, 3'd4, 32'hFFFFFFFC, {1'b1, 32'h0}, w);
`endif
    in_valid = 1'b0;
    drain("branch_drain");

    // Reserved op then a normal op
    drive(16'h1234, 3'd7, 32'h0, {1'b1, 32'h0}, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("reserved_err", {out_err, dout}, {1'b1, 32'h0});
    @(posedge clk); #1;
    drive(16'h1234, 3'd1, 32'h0, {1'b0, 32'h00001234}, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("after_reserved", {out_err, dout}, {1'b0, 32'h00001234});
    @(posedge clk); #1;

    // Backpressure: 4 entries, out_ready low
    out_ready = 1'b0;
    drive(16'h0011, 3'd1, 32'h0, model(16'h0011, 3'd1, 32'h0), w);
    drive(16'hF022, 3'd3, 32'h0, model(16'hF022, 3'd3, 32'h0), w);
    din = 16'h0033; ext_op = 3'd2; cur_exp = model(16'h0033, 3'd2, 32'h0); in_valid = 1'b1;
    @(negedge clk);
    check("bp_in_ready_low", {32'b0, in_ready}, 33'd0);
    check("bp_dout_first", {out_err, dout}, model(16'h0011, 3'd1, 32'h0));
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_in_ready_still_low", {32'b0, in_ready}, 33'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(16'h0033, 3'd2, 32'h0, model(16'h0033, 3'd2, 32'h0), w);
    drive(16'h8044, 3'd0, 32'h0, model(16'h8044, 3'd0, 32'h0), w);
    in_valid = 1'b0;
    drain("bp_drain");

    // Flush with full buffer and a pending input
    out_ready = 1'b0;
    drive(16'h0101, 3'd1, 32'h0, model(16'h0101, 3'd1, 32'h0), w);
    drive(16'h0202, 3'd1, 32'h0, model(16'h0202, 3'd1, 32'h0), w);
    din = 16'h0303; ext_op = 3'd1; cur_exp = model(16'h0303, 3'd1, 32'h0);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {32'b0, out_valid}, 33'd0);
    check("flush_in_ready", {32'b0, in_ready}, 33'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(16'h0404, 3'd0, 32'h0, model(16'h0404, 3'd0, 32'h0), w);
    in_valid = 1'b0;
    drain("flush_drain");

    // Flush while in_ready is high: presented input must be discarded
    out_ready = 1'b0;
    drive(16'h0505, 3'd2, 32'h0, model(16'h0505, 3'd2, 32'h0), w);
    din = 16'h0606; ext_op = 3'd1; cur_exp = model(16'h0606, 3'd1, 32'h0);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush2_out_valid", {32'b0, out_valid}, 33'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("flush2_drain");

    // Reset mid-stream with a full buffer
    out_ready = 1'b0;
    drive(16'h00F0, 3'd1, 32'h0, model(16'h00F0, 3'd1, 32'h0), w);
    drive(16'h8F0F, 3'd3, 32'h0, model(16'h8F0F, 3'd3, 32'h0), w);
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_out_valid", {32'b0, out_valid}, 33'd0);
    check("mrst_dout", {out_err, dout}, 33'd0);
    check("mrst_in_ready", {32'b0, in_ready}, 33'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(16'h7FFF, 3'd1, 32'h0, model(16'h7FFF, 3'd1, 32'h0), w);
    in_valid = 1'b0;
    drain("mrst_drain");

    // Random traffic with random backpressure
    n_acc = 0;
    for (int cyc = 0; cyc < 3000 && n_acc < 40; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        rd = IN_W'($urandom_range(0, 65535));
        rop = 3'($urandom_range(0, 7));
        rb = $urandom;
        e = model(rd, rop, rb);
        din = rd; ext_op = rop; base = rb; cur_exp = e; in_valid = 1'b1;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        n_acc++;
        in_valid = 1'b0;
      end
    end
    check("rand_accepted", 33'(n_acc), 33'd40);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
